// File: rtl/led_pkg.sv
// led_pkg: mode encoding shared by the LED PWM sequencer and its channels
package led_pkg;
    localparam int MODE_W = 2;
    localparam logic [MODE_W-1:0] LED_OFF     = 2'd0;
    localparam logic [MODE_W-1:0] LED_STATIC  = 2'd1;
    localparam logic [MODE_W-1:0] LED_BLINK   = 2'd2;
    localparam logic [MODE_W-1:0] LED_BREATHE = 2'd3;
endpackage

// File: rtl/led_pwm_chan.sv
// led_pwm_chan: one LED channel with mode state, blink/breathe generators and frame-latched PWM compare
module led_pwm_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int BLINK_DIV = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                frame_end_i,
    input  logic                step_tick_i,
    input  logic                cfg_we_i,
    input  logic [MODE_W-1:0]   cfg_mode_i,
    input  logic [PWM_BITS-1:0] cfg_level_i,
    output logic                led_o
);
    localparam int DIV_W = $clog2(BLINK_DIV + 1);
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [PWM_BITS-1:0] level_q, level_d, ramp_q, ramp_d, duty_q, duty_d, target, ramp_inc;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                up_q, up_d, phase_q, phase_d, led_d, div_wrap;
    assign ramp_inc = ramp_q + 1'b1;
    assign div_wrap = div_q == DIV_W'(BLINK_DIV - 1);
    // a config write wins over a coincident step_tick for this channel
    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        ramp_d  = ramp_q;
        up_d    = up_q;
        phase_d = phase_q;
        div_d   = div_q;
        if (cfg_we_i) begin
            mode_d  = cfg_mode_i;
            level_d = cfg_level_i;
            ramp_d  = '0;
            up_d    = 1'b1;
            phase_d = 1'b1;
            div_d   = '0;
        end else if (ramp_q > level_q) begin
            ramp_d = level_q;
            up_d   = 1'b0;
        end else if (step_tick_i) begin
            div_d   = div_wrap ? '0 : div_q + 1'b1;
            phase_d = phase_q ^ div_wrap;
            if (mode_q == LED_BREATHE) begin
                ramp_d = up_q ? ((ramp_q < level_q) ? ramp_inc : ramp_q)
                              : ((ramp_q != '0) ? ramp_q - 1'b1 : ramp_q);
                up_d   = up_q ? (ramp_inc < level_q) : (ramp_q <= PWM_BITS'(1));
            end
        end
    end
    assign target = (mode_q == LED_STATIC)  ? level_q :
                    (mode_q == LED_BLINK)   ? (phase_q ? level_q : '0) :
                    (mode_q == LED_BREATHE) ? ramp_q : '0;
    assign duty_d = frame_end_i ? target : duty_q;
    assign led_d  = pwm_cnt_i < duty_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= LED_OFF;
            level_q <= '0;
            ramp_q  <= '0;
            up_q    <= 1'b1;
            phase_q <= 1'b0;
            div_q   <= '0;
            duty_q  <= '0;
            led_o   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            level_q <= level_d;
            ramp_q  <= ramp_d;
            up_q    <= up_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            duty_q  <= duty_d;
            led_o   <= led_d;
        end
    end
endmodule

// File: rtl/led_pwm_sequencer.sv
// led_pwm_sequencer: multi-channel LED PWM driver with prescaler, shared frame counter and config port
module led_pwm_sequencer
    import led_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 4096,
    parameter int BLINK_DIV = 64,
    localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CHAN_W-1:0]   cfg_chan_i,
    input  logic [MODE_W-1:0]   cfg_mode_i,
    input  logic [PWM_BITS-1:0] cfg_level_i,
    output logic [CHANNELS-1:0] led_o,
    output logic                step_tick_o
);
    localparam int PRE_W = $clog2(PRESCALE);
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic                frame_end, accept;
    assign pre_d     = (pre_q == PRE_W'(PRESCALE - 1)) ? '0 : pre_q + 1'b1;
    assign frame_end = pwm_q == '1;
    assign accept    = cfg_valid_i & cfg_ready_o;
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            pwm_q       <= '0;
            step_tick_o <= 1'b0;
            cfg_ready_o <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            pwm_q       <= pwm_q + 1'b1;
            step_tick_o <= pre_d == PRE_W'(PRESCALE - 1);
            cfg_ready_o <= 1'b1;
        end
    end
    // out-of-range channel numbers are accepted but match no channel
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        led_pwm_chan #(
            .PWM_BITS  (PWM_BITS),
            .BLINK_DIV (BLINK_DIV)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .pwm_cnt_i   (pwm_q),
            .frame_end_i (frame_end),
            .step_tick_i (step_tick_o),
            .cfg_we_i    (accept && (cfg_chan_i == CHAN_W'(i))),
            .cfg_mode_i  (cfg_mode_i),
            .cfg_level_i (cfg_level_i),
            .led_o       (led_o[i])
        );
    end
endmodule

// File: tb/tb_led_pwm_sequencer.sv
// tb_led_pwm_sequencer: directed checks of reset, static, blink, breathe, tick-aligned writes and mid-frame reset
module tb_led_pwm_sequencer;
    import led_pkg::*;
    logic       clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0;
    logic [1:0] cfg_chan = '0, cfg_mode = '0;
    logic [3:0] cfg_level = '0;
    logic       cfg_ready, step_tick;
    logic [2:0] led;
    int cyc = 0, n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    // cyc tracks cycles since reset release, so cyc%16 is the PWM phase and cyc%4 the prescaler phase
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    // BLINK_DIV=8 gives the 8-tick (32-cycle) blink windows
    led_pwm_sequencer #(
        .CHANNELS  (3),
        .PWM_BITS  (4),
        .PRESCALE  (4),
        .BLINK_DIV (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_chan_i  (cfg_chan),
        .cfg_mode_i  (cfg_mode),
        .cfg_level_i (cfg_level),
        .led_o       (led),
        .step_tick_o (step_tick)
    );
    task automatic wait_mod(input int r);
        do @(negedge clk); while (cyc % 16 != r);
    endtask
    task automatic cfg_write(input int ch, input int m, input int lv);
        cfg_valid = 1'b1;
        cfg_chan  = 2'(ch);
        cfg_mode  = 2'(m);
        cfg_level = 4'(lv);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask
    task automatic measure(output int d0, output int d1, output int d2);
        d0 = 0;
        d1 = 0;
        d2 = 0;
        wait_mod(1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            d0 += int'(led[0]);
            d1 += int'(led[1]);
            d2 += int'(led[2]);
        end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_chk++;
            if (led !== 3'b000 || cfg_ready !== 1'b0 || step_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: led=%b ready=%b tick=%b, want 000/0/0", led, cfg_ready, step_tick);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", cfg_ready);
        end
        for (int i = 0; i < 12; i++) begin
            n_chk++;
            if (step_tick !== (cyc % 4 == 3)) begin
                n_fail++;
                $display("FAIL step_tick cyc=%0d: got %b want %b", cyc, step_tick, cyc % 4 == 3);
            end
            @(negedge clk);
        end
    endtask
    task automatic test_static;
        int d0, d1, d2;
        int lv[3]   = '{4, 0, 15};
        int prev[3] = '{0, 4, 0};
        for (int i = 0; i < 3; i++) begin
            wait_mod(15);
            cfg_write(0, LED_STATIC, lv[i]);
            measure(d0, d1, d2);
            n_chk++;
            if (d0 != prev[i] || d1 != 0 || d2 != 0) begin
                n_fail++;
                $display("FAIL static_hold %0d: duty %0d/%0d/%0d want %0d/0/0", i, d0, d1, d2, prev[i]);
            end
            measure(d0, d1, d2);
            n_chk++;
            if (d0 != lv[i] || d1 != 0 || d2 != 0) begin
                n_fail++;
                $display("FAIL static_level %0d: duty %0d/%0d/%0d want %0d/0/0", i, d0, d1, d2, lv[i]);
            end
        end
    endtask
    task automatic test_blink;
        int d0, d1, d2;
        int exp_b[7] = '{0, 15, 15, 0, 0, 15, 15};
        wait_mod(15);
        cfg_write(1, LED_BLINK, 15);
        for (int i = 0; i < 7; i++) begin
            measure(d0, d1, d2);
            n_chk++;
            if (d1 != exp_b[i]) begin
                n_fail++;
                $display("FAIL blink_frame %0d: duty %0d want %0d", i, d1, exp_b[i]);
            end
        end
    endtask
    task automatic test_breathe;
        int d0, d1, d2;
        int exp_r[6] = '{0, 3, 1, 1, 3, 1};
        wait_mod(15);
        cfg_write(2, LED_BREATHE, 3);
        for (int i = 0; i < 6; i++) begin
            measure(d0, d1, d2);
            n_chk++;
            if (d2 != exp_r[i]) begin
                n_fail++;
                $display("FAIL breathe_frame %0d: duty %0d want %0d", i, d2, exp_r[i]);
            end
        end
    endtask
    task automatic test_back_to_back;
        int d0, d1, d2;
        cfg_write(0, LED_OFF, 0);
        cfg_write(2, LED_OFF, 0);
        wait_mod(15);
        cfg_write(1, LED_BREATHE, 15);
        wait_mod(15);
        n_chk++;
        if (step_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_align: step_tick %b want 1", step_tick);
        end
        cfg_write(0, LED_BREATHE, 15);
        measure(d0, d1, d2);
        n_chk++;
        if (d0 != 0 || d1 != 3 || d2 != 0) begin
            n_fail++;
            $display("FAIL tick_write_a: duty %0d/%0d/%0d want 0/3/0", d0, d1, d2);
        end
        wait_mod(15);
        cfg_write(3, LED_STATIC, 9);
        measure(d0, d1, d2);
        n_chk++;
        if (d0 != 7 || d1 != 11 || d2 != 0) begin
            n_fail++;
            $display("FAIL tick_write_b: duty %0d/%0d/%0d want 7/11/0", d0, d1, d2);
        end
    endtask
    task automatic test_mid_reset;
        int d0, d1, d2;
        for (int c = 0; c < 3; c++) cfg_write(c, LED_STATIC, 15);
        measure(d0, d1, d2);
        measure(d0, d1, d2);
        n_chk++;
        if (d0 != 15 || d1 != 15 || d2 != 15) begin
            n_fail++;
            $display("FAIL all_on: duty %0d/%0d/%0d want 15/15/15", d0, d1, d2);
        end
        wait_mod(7);
        n_chk++;
        if (led !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_reset_led: got %b want 111", led);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (led !== 3'b000 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: led=%b ready=%b want 000/0", led, cfg_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_mid_reset: got %b want 1", cfg_ready);
        end
        for (int i = 0; i < 2; i++) begin
            measure(d0, d1, d2);
            n_chk++;
            if (d0 != 0 || d1 != 0 || d2 != 0) begin
                n_fail++;
                $display("FAIL off_after_reset %0d: duty %0d/%0d/%0d want 0/0/0", i, d0, d1, d2);
            end
        end
    endtask
    initial begin
        test_reset();
        test_static();
        test_blink();
        test_breathe();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
